// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: state encoding, parity modes and the parity check helper.
package uart_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    localparam logic PARITY_MODE_EVEN = 1'b0;
    localparam logic PARITY_MODE_ODD  = 1'b1;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t IDLE   = 3'd0;
    localparam rx_state_t START  = 3'd1;
    localparam rx_state_t DATA   = 3'd2;
    localparam rx_state_t PARITY = 3'd3;
    localparam rx_state_t STOP   = 3'd4;

    // True when the received parity bit disagrees with the data reduction for the chosen mode.
    function automatic logic parity_mismatch(input logic sample, input logic data_xor, input logic odd);
        return sample ^ data_xor ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line plus an armed flag that only allows a start
// after the line has been seen high while the receiver is idle.
module uart_rx_sync (
    input  logic rx_clk,
    input  logic rx_rst,
    input  logic rx_in,
    input  logic idle,
    output logic rs,
    output logic start_det
);

    logic [1:0] sync_reg;
    logic       armed_reg;

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            sync_reg  <= 2'b11;
            armed_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], rx_in};
            // Disarm while a frame is in flight so a break cannot retrigger without a high level.
            if (!idle) begin
                armed_reg <= 1'b0;
            end else if (sync_reg[1]) begin
                armed_reg <= 1'b1;
            end
        end
    end

    assign rs        = sync_reg[1];
    assign start_det = armed_reg & ~sync_reg[1];

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with configurable frame format and a valid/ready output
// holding the received word together with parity, stop and overrun status.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  rx_clk,
    input  logic                  rx_rst,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  parity_bit_error,
    output logic                  stop_bit_error,
    output logic                  overrun_error
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          ODD_MODE  = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

    rx_state_t             state_reg, state_next;
    logic [TW-1:0]         tick_reg, tick_next;
    logic [BW-1:0]         bit_cnt_reg, bit_cnt_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic                  err_p_reg, err_p_next;
    logic                  err_s_reg, err_s_next;
    logic                  commit_reg, commit_next;

    logic [DATA_WIDTH-1:0] data_reg;
    logic                  valid_reg, perr_reg, serr_reg, ovr_reg;

    logic rs, start_det, mid;

    uart_rx_sync u_sync (
        .rx_clk    (rx_clk),
        .rx_rst    (rx_rst),
        .rx_in     (rx_in),
        .idle      (state_reg == IDLE),
        .rs        (rs),
        .start_det (start_det)
    );

    assign mid = (tick_reg == TICK_LAST);

    always_comb begin
        state_next   = state_reg;
        tick_next    = mid ? '0 : tick_reg + 1'b1;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        err_p_next   = err_p_reg;
        err_s_next   = err_s_reg;
        commit_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                tick_next    = '0;
                bit_cnt_next = '0;
                if (start_det) begin
                    state_next = START;
                end
            end
            START: begin
                // Half a bit in: re-check the line, then count whole bit periods from the centre.
                if (tick_reg == TICK_MID) begin
                    tick_next  = '0;
                    err_p_next = 1'b0;
                    err_s_next = 1'b0;
                    state_next = rs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (mid) begin
                    shift_next   = {rs, shift_reg[DATA_WIDTH-1:1]};
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == DATA_LAST) begin
                        bit_cnt_next = '0;
                        state_next   = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (mid) begin
                    err_p_next = parity_mismatch(rs, ^shift_reg, ODD_MODE);
                    state_next = STOP;
                end
            end
            STOP: begin
                if (mid) begin
                    err_s_next   = err_s_reg | ~rs;
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == STOP_LAST) begin
                        state_next  = IDLE;
                        commit_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state_reg   <= IDLE;
            tick_reg    <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            err_p_reg   <= 1'b0;
            err_s_reg   <= 1'b0;
            commit_reg  <= 1'b0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            perr_reg    <= 1'b0;
            serr_reg    <= 1'b0;
            ovr_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tick_reg    <= tick_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            err_p_reg   <= err_p_next;
            err_s_reg   <= err_s_next;
            commit_reg  <= commit_next;
            ovr_reg     <= 1'b0;
            if (commit_reg && (!valid_reg || rx_ready)) begin
                data_reg  <= shift_reg;
                perr_reg  <= err_p_reg;
                serr_reg  <= err_s_reg;
                valid_reg <= 1'b1;
            end else begin
                // A full output drops the new frame; the held word stays untouched.
                if (commit_reg) begin
                    ovr_reg <= 1'b1;
                end
                if (valid_reg && rx_ready) begin
                    valid_reg <= 1'b0;
                end
            end
        end
    end

    assign rx_data          = data_reg;
    assign rx_valid         = valid_reg;
    assign parity_bit_error = perr_reg;
    assign stop_bit_error   = serr_reg;
    assign overrun_error    = ovr_reg;

endmodule
